adc_capture_sequencer: RTL and testbench

ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

---
 rtl/adc_capture_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_adc_capture_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_sequencer.sv
// ADC capture sequencer: Avalon-MM control registers, power-up/arm/capture FSM
// and a sample stream with no backpressure (unready beats are counted as drops).
module adc_capture_sequencer #(
    parameter int DATA_W    = 14,
    parameter int PU_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              trig,
    output logic              adc_pdwn,
    output logic [7:0]        adc_ctrl,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    output logic              st_eop,
    input  logic              st_ready
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAKE    = 3'd1,
        ARMED   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int PU_W = (PU_CYCLES > 1) ? $clog2(PU_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [7:0]        ctrl_q, ctrl_d;
    logic              trig_en_q, trig_en_d;
    logic              run_trig_en_q, run_trig_en_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       run_n_q, run_n_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       smp_cnt_q, smp_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [PU_W-1:0]   pu_cnt_q, pu_cnt_d;
    logic              trig_prev_q;
    logic [DATA_W-1:0] st_data_q, st_data_d;
    logic              st_valid_q, st_valid_d;
    logic              st_eop_q, st_eop_d;
    logic              wr, start, abort, trig_rise;
    logic              unused_wd;

    assign wr        = chipselect & ~write_n;
    assign start     = wr && (address == 2'd0) && writedata[0];
    assign abort     = wr && (address == 2'd0) && writedata[1];
    assign trig_rise = trig & ~trig_prev_q;
    assign unused_wd = ^writedata[31:16];

    always_comb begin
        state_d       = state_q;
        ctrl_d        = ctrl_q;
        trig_en_d     = trig_en_q;
        run_trig_en_d = run_trig_en_q;
        n_d           = n_q;
        run_n_d       = run_n_q;
        done_d        = done_q;
        err_d         = err_q;
        smp_cnt_d     = smp_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        pu_cnt_d      = pu_cnt_q;
        st_data_d     = st_data_q;
        st_valid_d    = 1'b0;
        st_eop_d      = 1'b0;

        if (wr && address == 2'd0) begin
            ctrl_d    = writedata[15:8];
            trig_en_d = writedata[2];
        end
        if (wr && address == 2'd1) n_d = writedata[15:0];
        if (wr && address == 2'd2) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end

        if (st_valid_q && !st_ready && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
        if (wr && address == 2'd3) drop_cnt_d = 16'd0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (n_q != 16'd0) begin
                        // Run parameters are snapshotted so mid-run writes wait for the next START.
                        state_d       = WAKE;
                        run_n_d       = n_q;
                        run_trig_en_d = writedata[2];
                        smp_cnt_d     = 16'd0;
                        pu_cnt_d      = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAKE: begin
                if (pu_cnt_q == PU_W'(PU_CYCLES - 1)) state_d = ARMED;
                else pu_cnt_d = pu_cnt_q + PU_W'(1);
            end
            ARMED: begin
                if (!run_trig_en_q || trig_rise) state_d = CAPTURE;
            end
            CAPTURE: begin
                st_data_d  = adc_data;
                st_valid_d = 1'b1;
                smp_cnt_d  = smp_cnt_q + 16'd1;
                if (smp_cnt_q == run_n_q - 16'd1) begin
                    st_eop_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            st_valid_d = 1'b0;
            st_eop_d   = 1'b0;
            done_d     = done_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ctrl_q        <= 8'd0;
            trig_en_q     <= 1'b0;
            run_trig_en_q <= 1'b0;
            n_q           <= 16'd0;
            run_n_q       <= 16'd0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            smp_cnt_q     <= 16'd0;
            drop_cnt_q    <= 16'd0;
            pu_cnt_q      <= '0;
            trig_prev_q   <= 1'b0;
            st_data_q     <= '0;
            st_valid_q    <= 1'b0;
            st_eop_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            trig_en_q     <= trig_en_d;
            run_trig_en_q <= run_trig_en_d;
            n_q           <= n_d;
            run_n_q       <= run_n_d;
            done_q        <= done_d;
            err_q         <= err_d;
            smp_cnt_q     <= smp_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            pu_cnt_q      <= pu_cnt_d;
            trig_prev_q   <= trig;
            st_data_q     <= st_data_d;
            st_valid_q    <= st_valid_d;
            st_eop_q      <= st_eop_d;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: readdata = {16'd0, ctrl_q, 5'd0, trig_en_q, 2'b00};
            2'd1: readdata = {16'd0, n_q};
            2'd2: readdata = {smp_cnt_q, 10'd0, err_q, (state_q != IDLE), done_q, state_q};
            2'd3: readdata = {16'd0, drop_cnt_q};
            default: readdata = 32'd0;
        endcase
    end

    assign adc_pdwn = (state_q == IDLE);
    assign adc_ctrl = ctrl_q;
    assign st_data  = st_data_q;
    assign st_valid = st_valid_q;
    assign st_eop   = st_eop_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: runs are predicted from the sequencing rules
// by cycle arithmetic, expected beats queued, and a monitor scores the stream.
module tb_adc_capture_sequencer;
    localparam int DW   = 14;
    localparam int PU   = 64;
    localparam int MEMN = 8192;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'd0;
    logic [31:0]   readdata;
    logic [DW-1:0] adc_data = '0;
    logic          trig = 1'b0;
    logic          adc_pdwn;
    logic [7:0]    adc_ctrl;
    logic [DW-1:0] st_data;
    logic          st_valid;
    logic          st_eop;
    logic          st_ready = 1'b1;

    adc_capture_sequencer #(.DATA_W(DW), .PU_CYCLES(PU)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .adc_data(adc_data), .trig(trig), .adc_pdwn(adc_pdwn), .adc_ctrl(adc_ctrl),
        .st_data(st_data), .st_valid(st_valid), .st_eop(st_eop), .st_ready(st_ready)
    );

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic          eop;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] adc_mem   [MEMN];
    logic          trig_mem  [MEMN];
    logic          ready_mem [MEMN];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Per-cycle input driver: cycle k presents adc_mem[k], trig_mem[k], ready_mem[k].
    initial begin
        for (int i = 0; i < MEMN; i++) begin
            adc_mem[i]   = DW'($urandom);
            trig_mem[i]  = 1'b0;
            ready_mem[i] = 1'b1;
        end
        forever begin
            @(posedge clk);
            #1;
            adc_data = adc_mem[cyc % MEMN];
            trig     = trig_mem[cyc % MEMN];
            st_ready = ready_mem[cyc % MEMN];
        end
    end

    initial begin : monitor
        beat_t b;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (st_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got st_valid=1 data=0x%0h at cycle %0d, required no beat",
                                 st_data, cyc);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_cycle", 32'(cyc), 32'(b.cyc));
                        chk("beat_data", 32'(st_data), 32'(b.data));
                        chk("beat_eop", 32'(st_eop), 32'(b.eop));
                    end
                end else begin
                    chk("eop_without_valid", 32'(st_eop), 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int wcyc);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        wcyc       = cyc;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] mask,
                      input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata & mask, exp);
    endtask

    // stop_kind: 0 = run to completion, 1 = ABORT during beat stop_at, 2 = reset during beat stop_at
    task automatic run(input int n, input bit ten, input int tmode, input logic [31:0] rmask,
                       input bit poke, input int stop_kind, input int stop_at);
        int         w, a, cs, t, drops, nb, dmy;
        logic [7:0] ctrl;
        beat_t      b;
        ctrl  = 8'($urandom);
        drops = 0;
        wr(2'd3, 32'd0, dmy);
        wr(2'd2, 32'd0, dmy);
        wr(2'd1, 32'(n), dmy);
        chk("pdwn_idle", 32'(adc_pdwn), 32'd1);
        w = cyc;
        a = w + PU + 1;
        for (int k = w + 1; k < a + 40 + n; k++) trig_mem[k % MEMN] = 1'($urandom);
        if (tmode == 1) begin
            for (int k = w + 1; k <= a + 3; k++) trig_mem[k % MEMN] = 1'b1;
            trig_mem[(a + 4) % MEMN] = 1'b0;
            for (int k = a + 5; k < a + 40 + n; k++) trig_mem[k % MEMN] = 1'b1;
        end else if (tmode == 2) begin
            trig_mem[(a + 20) % MEMN] = 1'b0;
            trig_mem[(a + 21) % MEMN] = 1'b1;
        end
        cs = a + 1;
        if (ten) begin
            t = a;
            while (t < a + 30 && !(trig_mem[t % MEMN] && !trig_mem[(t - 1) % MEMN])) t++;
            cs = t + 1;
        end
        wr(2'd0, {16'd0, ctrl, 5'd0, ten, 2'b01}, w);
        chk("pdwn_wake", 32'(adc_pdwn), 32'd0);

        nb = (stop_kind == 1) ? stop_at : (stop_kind == 2) ? stop_at - 1 : n;
        for (int j = 1; j <= nb; j++) begin
            ready_mem[(cs + j) % MEMN] = rmask[j - 1];
            if (!rmask[j - 1]) drops++;
            b.cyc  = cs + j;
            b.data = adc_mem[(cs + j - 1) % MEMN];
            b.eop  = (j == n);
            exp_q.push_back(b);
        end

        if (poke) begin
            tick(3);
            wr(2'd1, 32'd3, dmy);
            wr(2'd0, 32'h0000_5A05, dmy);
            rd("ctrl_live_read", 2'd0, 32'hFFFF_FFFF, 32'h0000_5A04);
            chk("adc_ctrl_live", 32'(adc_ctrl), 32'h5A);
        end

        if (stop_kind == 1) begin
            wait_until(cs + stop_at);
            wr(2'd0, {16'd0, ctrl, 8'h02}, dmy);
            chk("valid_after_abort", 32'(st_valid), 32'd0);
            rd("abort_status", 2'd2, 32'h3F, 32'h0);
            chk("pdwn_after_abort", 32'(adc_pdwn), 32'd1);
            tick(3);
            chk("beats_left", 32'(exp_q.size()), 32'd0);
        end else if (stop_kind == 2) begin
            wait_until(cs + stop_at);
            #1;
            reset = 1'b1;
            #1;
            chk("rst_st_valid", 32'(st_valid), 32'd0);
            chk("rst_st_eop", 32'(st_eop), 32'd0);
            chk("rst_st_data", 32'(st_data), 32'd0);
            chk("rst_pdwn", 32'(adc_pdwn), 32'd1);
            chk("rst_adc_ctrl", 32'(adc_ctrl), 32'd0);
            for (int r = 0; r < 4; r++) rd("rst_reg", 2'(r), 32'hFFFF_FFFF, 32'd0);
            chk("beats_left", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            @(posedge clk);
            #1;
            reset = 1'b0;
            tick(5);
            rd("post_rst_status", 2'd2, 32'hFFFF_FFFF, 32'd0);
            chk("post_rst_pdwn", 32'(adc_pdwn), 32'd1);
        end else begin
            wait_until(cs + n);
            chk("pdwn_done_state", 32'(adc_pdwn), 32'd0);
            tick(1);
            chk("pdwn_after_done", 32'(adc_pdwn), 32'd1);
            rd("run_status", 2'd2, 32'hFFFF_FFFF, (32'(n) << 16) | 32'h8);
            rd("run_drops", 2'd3, 32'hFFFF_FFFF, 32'(drops));
            chk("beats_left", 32'(exp_q.size()), 32'd0);
            if (poke) rd("n_readback", 2'd1, 32'hFFFF_FFFF, 32'd3);
        end
        tick(2);
    endtask

    initial begin
        int dmy;
        int rn;
        bit rt;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_pdwn", 32'(adc_pdwn), 32'd1);
        chk("reset_adc_ctrl", 32'(adc_ctrl), 32'd0);
        chk("reset_st_valid", 32'(st_valid), 32'd0);
        chk("reset_st_eop", 32'(st_eop), 32'd0);
        chk("reset_st_data", 32'(st_data), 32'd0);
        for (int r = 0; r < 4; r++) rd("reset_reg", 2'(r), 32'hFFFF_FFFF, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(2);

        run(4, 1'b0, 0, 32'hFFFF_FFFF, 1'b0, 0, 0);
        run(5, 1'b0, 0, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run(6, 1'b1, 1, 32'hFFFF_FFFF, 1'b0, 0, 0);
        run(8, 1'b0, 0, 32'hFFFF_FFEB, 1'b0, 0, 0);
        repeat (6) begin
            rn = $urandom_range(1, 12);
            rt = 1'($urandom_range(0, 1));
            run(rn, rt, rt ? 2 : 0, $urandom, 1'b0, 0, 0);
        end
        run(10, 1'b0, 0, 32'hFFFF_FFFF, 1'b0, 1, 2);

        wr(2'd2, 32'd0, dmy);
        wr(2'd1, 32'd0, dmy);
        wr(2'd0, 32'h0000_0001, dmy);
        rd("err_n0_status", 2'd2, 32'h3F, 32'h20);
        chk("err_n0_pdwn", 32'(adc_pdwn), 32'd1);

        wr(2'd2, 32'd0, dmy);
        wr(2'd1, 32'd5, dmy);
        wr(2'd0, 32'h0000_0003, dmy);
        rd("start_abort_status", 2'd2, 32'h3F, 32'h0);
        chk("start_abort_pdwn", 32'(adc_pdwn), 32'd1);
        tick(PU + 12);
        rd("start_abort_later", 2'd2, 32'h3F, 32'h0);

        run(10, 1'b0, 0, 32'hFFFF_FFFF, 1'b0, 2, 3);
        wr(2'd0, 32'h0000_A500, dmy);
        chk("ctrl_a5", 32'(adc_ctrl), 32'hA5);
        rd("ctrl_a5_read", 2'd0, 32'hFFFF_FFFF, 32'h0000_A500);
        tick(3);
        rd("ctrl_a5_status", 2'd2, 32'hFFFF_FFFF, 32'd0);
        chk("ctrl_a5_pdwn", 32'(adc_pdwn), 32'd1);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
